// File: rtl/sdf_delay_buffer.sv
// sdf_delay_buffer
//   Complex (Re/Im) runtime-programmable delay buffer for radix-2^2 SDF FFT
//   stages. Implemented as a circular buffer with read-before-write at a
//   single pointer. Samples advance only on in_valid; stalls hold contents.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid          advance strobe, in_re/in_im accepted when high
//   in_re, in_im      signed input sample
//   cfg_load          load depth_cfg as the new delay (implies flush)
//   depth_cfg         requested delay D, legal range 1..MAX_DEPTH
//   flush             discard buffered samples
//   out_re, out_im    sample delayed by D advances
//   out_valid         out_re/out_im carry a real delayed sample this cycle
//   primed            buffer holds D samples
//   cfg_err           one-cycle pulse when depth_cfg is rejected
//
// Optional build macro SDF_DELAY_OCCUPANCY_EN adds:
//   fill_level        current fill count (saturates at depth)
//   ptr_dbg           current read/write pointer
module sdf_delay_buffer #(
   parameter int WIDTH     = 16,
   parameter int MAX_DEPTH = 8,
   parameter int DEPTH_W   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic signed [WIDTH-1:0]   in_re,
   input  logic signed [WIDTH-1:0]   in_im,
   input  logic                      cfg_load,
   input  logic        [DEPTH_W-1:0] depth_cfg,
   input  logic                      flush,
   output logic signed [WIDTH-1:0]   out_re,
   output logic signed [WIDTH-1:0]   out_im,
   output logic                      out_valid,
   output logic                      primed,
   output logic                      cfg_err
`ifdef SDF_DELAY_OCCUPANCY_EN
   ,
   output logic        [DEPTH_W-1:0] fill_level,
   output logic        [DEPTH_W-1:0] ptr_dbg
`endif
);

   localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic        [DEPTH_W-1:0] depth_q, depth_d;
   logic        [DEPTH_W-1:0] ptr_q,   ptr_d;
   logic        [DEPTH_W-1:0] fill_q,  fill_d;
   logic signed [WIDTH-1:0]   out_re_q, out_re_d;
   logic signed [WIDTH-1:0]   out_im_q, out_im_d;
   logic                      out_valid_q, out_valid_d;
   logic                      cfg_err_q, cfg_err_d;
   logic signed [WIDTH-1:0]   mem_re_q [MAX_DEPTH];
   logic signed [WIDTH-1:0]   mem_im_q [MAX_DEPTH];

   logic                      clr;   // flush, explicit or implied by a good cfg_load
   logic                      adv;   // accepted advance
   logic                      cfg_ok;
   logic        [AW-1:0]      idx;

   assign cfg_ok = (depth_cfg != '0) && (depth_cfg <= DEPTH_W'(MAX_DEPTH));
   assign idx    = ptr_q[AW-1:0];

   always_comb begin
      state_d     = state_q;
      depth_d     = depth_q;
      ptr_d       = ptr_q;
      fill_d      = fill_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      out_valid_d = 1'b0;
      cfg_err_d   = 1'b0;
      clr         = 1'b0;
      adv         = 1'b0;

      // Priority: cfg_load > flush > in_valid (rst handled in the register)
      if (cfg_load) begin
         if (cfg_ok) begin
            depth_d = depth_cfg;
            clr     = 1'b1;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else if (flush) begin
         clr = 1'b1;
      end else if (in_valid) begin
         adv = 1'b1;
      end

      if (clr) begin
         state_d  = EMPTY;
         ptr_d    = '0;
         fill_d   = '0;
         out_re_d = '0;
         out_im_d = '0;
      end

      if (adv) begin
         // Read-before-write: the slot about to be overwritten holds the
         // sample accepted exactly depth advances ago.
         out_re_d    = mem_re_q[idx];
         out_im_d    = mem_im_q[idx];
         out_valid_d = (state_q == RUN);
         ptr_d       = (ptr_q == depth_q - DEPTH_W'(1)) ? '0 : ptr_q + DEPTH_W'(1);
         unique case (state_q)
            EMPTY: begin
               fill_d  = DEPTH_W'(1);
               state_d = (depth_q == DEPTH_W'(1)) ? RUN : FILL;
            end
            FILL: begin
               fill_d = fill_q + DEPTH_W'(1);
               if (fill_q + DEPTH_W'(1) == depth_q) state_d = RUN;
            end
            default: begin
               fill_d = fill_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         depth_q     <= DEPTH_W'(MAX_DEPTH);
         ptr_q       <= '0;
         fill_q      <= '0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         mem_re_q    <= '{default: '0};
         mem_im_q    <= '{default: '0};
      end else begin
         state_q     <= state_d;
         depth_q     <= depth_d;
         ptr_q       <= ptr_d;
         fill_q      <= fill_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         out_valid_q <= out_valid_d;
         cfg_err_q   <= cfg_err_d;
         if (clr) begin
            mem_re_q <= '{default: '0};
            mem_im_q <= '{default: '0};
         end else if (adv) begin
            mem_re_q[idx] <= in_re;
            mem_im_q[idx] <= in_im;
         end
      end
   end

   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign out_valid = out_valid_q;
   assign primed    = (state_q == RUN);
   assign cfg_err   = cfg_err_q;

`ifdef SDF_DELAY_OCCUPANCY_EN
   assign fill_level = fill_q;
   assign ptr_dbg    = ptr_q;
`endif

endmodule
